// File: rtl/matrix_fifo_loader_if.sv
// Bundle between the MAC-array FIFO loader and its memory port, FIFO bank and controller.
// master is the loader side; slave is the memory / FIFO / controller side.
// Carries start/busy/done, the read-only memory handshake and the per-FIFO write lanes.
interface matrix_fifo_loader_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ROWS       = 8,
  parameter int COLS       = 8,
  parameter int ADDR_WIDTH = 32
);
  logic                       start;
  logic [ADDR_WIDTH-1:0]      mem_address;
  logic                       mem_read;
  logic                       mem_waitreq;
  logic [COLS*DATA_WIDTH-1:0] mem_readdata;
  logic                       mem_rdvalid;
  logic [ROWS*DATA_WIDTH-1:0] data_A;
  logic [ROWS-1:0]            wrreq_A;
  logic [ROWS-1:0]            wrfull_A;
  logic [DATA_WIDTH-1:0]      data_B;
  logic                       wrreq_B;
  logic                       wrfull_B;
  logic                       busy;
  logic                       done;

  modport master (
    input  start, mem_waitreq, mem_readdata, mem_rdvalid, wrfull_A, wrfull_B,
    output mem_address, mem_read, data_A, wrreq_A, data_B, wrreq_B, busy, done
  );

  modport slave (
    output start, mem_waitreq, mem_readdata, mem_rdvalid, wrfull_A, wrfull_B,
    input  mem_address, mem_read, data_A, wrreq_A, data_B, wrreq_B, busy, done
  );
endinterface

// File: rtl/matrix_fifo_loader.sv
// Fetches ROWS+1 memory words (A rows, then B) and unpacks each byte-serially into its FIFO.
// Latency: per word 1 request cycle + memory latency + COLS push cycles; done pulses one cycle after the last write.
// Backpressure: mem_waitreq holds the request; a full target FIFO stalls the byte in place (no loss, no duplicate).
module matrix_fifo_loader #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    ROWS       = 8,
  parameter int                    COLS       = 8,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input logic                  clk,
  input logic                  rst,
  matrix_fifo_loader_if.master bus
);

  localparam int WW = $clog2(ROWS + 1);
  localparam int KW = (COLS > 1) ? $clog2(COLS) : 1;

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_PUSH, S_DONE} state_t;

  state_t                     state_q;
  logic [WW-1:0]              word_q;
  logic [KW-1:0]              byte_q;
  logic [COLS*DATA_WIDTH-1:0] line_q;
  logic [ADDR_WIDTH-1:0]      addr_q;
  logic                       read_q;
  logic                       busy_q;
  logic                       done_q;
  logic [ROWS*DATA_WIDTH-1:0] data_a_q;
  logic [DATA_WIDTH-1:0]      data_b_q;

  logic                       is_b_d;
  logic                       tgt_full_d;
  logic                       push_d;
  logic                       last_byte_d;
  logic [COLS*DATA_WIDTH-1:0] line_shift_d;
  logic                       lane_we_d;
  logic [DATA_WIDTH-1:0]      lane_byte_d;
  logic [ROWS-1:0]            wrreq_a;
  logic                       wrreq_b;

  // Target selection and write strobe; the strobe must react to the full flag in the same cycle
  always_comb begin
    is_b_d       = (word_q == WW'(ROWS));
    tgt_full_d   = bus.wrfull_B;
    for (int i = 0; i < ROWS; i++) begin
      if (word_q == WW'(i)) tgt_full_d = bus.wrfull_A[i];
    end
    push_d       = (state_q == S_PUSH) && !tgt_full_d;
    last_byte_d  = (byte_q == KW'(COLS - 1));
    line_shift_d = line_q >> DATA_WIDTH;
    wrreq_a      = '0;
    for (int i = 0; i < ROWS; i++) begin
      wrreq_a[i] = push_d && (word_q == WW'(i));
    end
    wrreq_b      = push_d && is_b_d;
    // The lane register is preloaded with the byte that will be offered next
    lane_we_d    = ((state_q == S_WAIT) && bus.mem_rdvalid) || (push_d && !last_byte_d);
    lane_byte_d  = (state_q == S_WAIT) ? bus.mem_readdata[DATA_WIDTH-1:0]
                                       : line_shift_d[DATA_WIDTH-1:0];
  end

  // Fill sequencer: request a word, wait for it, then unpack it one byte per free FIFO cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      word_q  <= '0;
      byte_q  <= '0;
      line_q  <= '0;
      addr_q  <= '0;
      read_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            word_q  <= '0;
            addr_q  <= BASE_ADDR;
            read_q  <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= S_REQ;
          end
        end
        S_REQ: begin
          if (!bus.mem_waitreq) begin
            read_q  <= 1'b0;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.mem_rdvalid) begin
            line_q  <= bus.mem_readdata;
            byte_q  <= '0;
            state_q <= S_PUSH;
          end
        end
        S_PUSH: begin
          if (push_d) begin
            line_q <= line_shift_d;
            byte_q <= byte_q + 1'b1;
            if (last_byte_d) begin
              if (is_b_d) begin
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                state_q <= S_DONE;
              end else begin
                word_q  <= word_q + 1'b1;
                addr_q  <= addr_q + 1'b1;
                read_q  <= 1'b1;
                state_q <= S_REQ;
              end
            end
          end
        end
        S_DONE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Data lanes: only the lane of the current word is updated, the others keep their last byte
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_a_q <= '0;
      data_b_q <= '0;
    end else if (lane_we_d) begin
      if (is_b_d) begin
        data_b_q <= lane_byte_d;
      end
      for (int i = 0; i < ROWS; i++) begin
        if (!is_b_d && (word_q == WW'(i))) data_a_q[i*DATA_WIDTH +: DATA_WIDTH] <= lane_byte_d;
      end
    end
  end

  assign bus.mem_address = addr_q;
  assign bus.mem_read    = read_q;
  assign bus.data_A      = data_a_q;
  assign bus.data_B      = data_b_q;
  assign bus.wrreq_A     = wrreq_a;
  assign bus.wrreq_B     = wrreq_b;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;

endmodule

// File: tb/tb_matrix_fifo_loader.sv
// Bench for matrix_fifo_loader: reactive memory with configurable latency/wait, FIFO full injection,
// spurious rdvalid/start, and a scoreboard of the (FIFO, byte) write sequence each fill must produce.
// Done timing is pinned against hand-derived cycle counts for the deterministic fills.
module tb_matrix_fifo_loader;
  localparam int DW    = 8;
  localparam int ROWS  = 8;
  localparam int COLS  = 8;
  localparam int AW    = 32;
  localparam logic [AW-1:0] BASE = 32'd16;
  localparam int TOTAL = (ROWS + 1) * COLS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  matrix_fifo_loader_if #(.DATA_WIDTH(DW), .ROWS(ROWS), .COLS(COLS), .ADDR_WIDTH(AW)) bus ();

  matrix_fifo_loader #(
    .DATA_WIDTH(DW), .ROWS(ROWS), .COLS(COLS), .ADDR_WIDTH(AW), .BASE_ADDR(BASE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference model: memory contents and the write sequence they imply
  logic [COLS*DW-1:0] mem_words [ROWS+1];
  int                 exp_f [TOTAL];
  logic [DW-1:0]      exp_d [TOTAL];

  // Configuration written by the main sequence only
  int lat = 1, w2_wait = 0, wait_pct = 0, full_pct = 0, go_req = 0;
  bit full5_en = 0, spur = 0;

  // State owned by the engine process
  int cyc = 0, go_ack = 0, t0 = 0, pos = 0, reads_acc = 0, last_wr = 0, done_cyc = 0;
  int w2_left = 0, w2_rd = 0, full5_cnt = 0, b2_cyc = 0, b3_cyc = 0;
  bit fill_active = 0, done_seen = 0, full5_arm = 0, acc = 0;
  logic [AW-1:0] acc_addr = '0;
  int pend_cnt[$];
  logic [AW-1:0] pend_addr[$];

  // Engine: checks outputs mid-cycle, then drives memory/FIFO/start inputs just after the edge
  initial begin : engine
    bus.start = 1'b0; bus.mem_waitreq = 1'b0; bus.mem_readdata = '0; bus.mem_rdvalid = 1'b0;
    bus.wrfull_A = '0; bus.wrfull_B = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend_cnt.delete(); pend_addr.delete();
        acc = 1'b0; fill_active = 1'b0;
      end else begin
        int nw, f;
        logic [DW-1:0] d;
        logic fl;
        nw = $countones(bus.wrreq_A) + int'(bus.wrreq_B);
        check("single_write", nw <= 1, 1'b1);
        if (nw == 1 && fill_active && pos < TOTAL) begin
          f = ROWS;
          for (int i = 0; i < ROWS; i++) if (bus.wrreq_A[i]) f = i;
          d  = bus.wrreq_B ? bus.data_B : bus.data_A[f*DW +: DW];
          fl = bus.wrreq_B ? bus.wrfull_B : bus.wrfull_A[f];
          check("write_fifo", f, exp_f[pos]);
          check("write_byte", d, exp_d[pos]);
          check("write_while_full", fl, 1'b0);
          if (pos == 5*COLS + 2) begin
            b2_cyc = cyc;
            if (full5_arm) begin full5_cnt = 4; full5_arm = 1'b0; end
          end
          if (pos == 5*COLS + 3) b3_cyc = cyc;
          pos++;
          last_wr = cyc;
        end else if (nw > 0) begin
          check("unexpected_write", nw, 0);
        end
        if (bus.mem_read) begin
          check("read_addr", bus.mem_address, BASE + reads_acc);
          check("busy_while_read", bus.busy, 1'b1);
          if (bus.mem_address == BASE + 2) w2_rd++;
          if (!bus.mem_waitreq) reads_acc++;
        end
        if (bus.done) begin
          check("done_in_fill", fill_active, 1'b1);
          check("done_all_written", pos, TOTAL);
          check("done_after_last_write", cyc - last_wr, 1);
          check("done_busy_low", bus.busy, 1'b0);
          done_seen = 1'b1; done_cyc = cyc; fill_active = 1'b0;
        end else if (!fill_active) begin
          check("idle_quiet", {bus.busy, bus.mem_read}, 2'b00);
        end
        acc      = bus.mem_read && !bus.mem_waitreq;
        acc_addr = bus.mem_address;
      end

      @(posedge clk);
      cyc++;
      #1;
      // start: a new fill, or a stray pulse while busy
      bus.start = 1'b0;
      if (go_req != go_ack) begin
        go_ack = go_req; bus.start = 1'b1; t0 = cyc;
        pos = 0; reads_acc = 0; done_seen = 1'b0; fill_active = 1'b1;
        w2_left = w2_wait; w2_rd = 0; full5_arm = full5_en; full5_cnt = 0; b2_cyc = 0; b3_cyc = 0;
      end else if (spur && bus.busy && $urandom_range(0, 2) == 0) begin
        bus.start = 1'b1;
      end
      // memory read return after lat cycles, otherwise maybe a stray rdvalid
      if (acc) begin pend_cnt.push_back(lat); pend_addr.push_back(acc_addr); end
      bus.mem_rdvalid = 1'b0;
      if (pend_cnt.size() > 0) begin
        pend_cnt[0] = pend_cnt[0] - 1;
        if (pend_cnt[0] == 0) begin
          int idx;
          idx = int'(pend_addr[0] - BASE);
          bus.mem_rdvalid = 1'b1;
          if (idx >= 0 && idx <= ROWS) bus.mem_readdata = mem_words[idx];
          else begin
            check("mem_addr_range", pend_addr[0], BASE);
            bus.mem_readdata = '0;
          end
          void'(pend_cnt.pop_front()); void'(pend_addr.pop_front());
        end
      end else if (spur && $urandom_range(0, 3) == 0) begin
        bus.mem_rdvalid  = 1'b1;
        bus.mem_readdata = {$urandom, $urandom};
      end
      // memory wait states
      bus.mem_waitreq = 1'b0;
      if (bus.mem_read) begin
        if (w2_left > 0 && bus.mem_address == BASE + 2) begin
          bus.mem_waitreq = 1'b1; w2_left--;
        end else if (wait_pct > 0 && int'($urandom_range(0, 99)) < wait_pct) begin
          bus.mem_waitreq = 1'b1;
        end
      end
      // FIFO full flags
      bus.wrfull_A = '0; bus.wrfull_B = 1'b0;
      if (full_pct > 0) begin
        for (int i = 0; i < ROWS; i++) bus.wrfull_A[i] = (int'($urandom_range(0, 99)) < full_pct);
        bus.wrfull_B = (int'($urandom_range(0, 99)) < full_pct);
      end
      if (full5_cnt > 0) begin bus.wrfull_A[5] = 1'b1; full5_cnt--; end
    end
  end

  task automatic check_reset(input string tag);
    check({tag, "_addr"},    bus.mem_address, 0);
    check({tag, "_read"},    bus.mem_read, 0);
    check({tag, "_data_A"},  bus.data_A, 0);
    check({tag, "_data_B"},  bus.data_B, 0);
    check({tag, "_wrreq_A"}, bus.wrreq_A, 0);
    check({tag, "_wrreq_B"}, bus.wrreq_B, 0);
    check({tag, "_busy"},    bus.busy, 0);
    check({tag, "_done"},    bus.done, 0);
  endtask

  // Load memory (ramp pattern or random) and launch one fill
  task automatic launch(input bit pattern);
    for (int w = 0; w <= ROWS; w++) begin
      for (int k = 0; k < COLS; k++) begin
        logic [DW-1:0] b;
        b = pattern ? DW'(w*COLS + k) : DW'($urandom);
        mem_words[w][k*DW +: DW] = b;
        exp_f[w*COLS + k] = w;
        exp_d[w*COLS + k] = b;
      end
    end
    go_req++;
    for (int i = 0; i < 10 && go_ack != go_req; i++) @(posedge clk);
    check("launch_ack", go_ack, go_req);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 4000 && !done_seen; i++) @(posedge clk);
    if (!done_seen) begin
      check({tag, "_done_timeout"}, done_seen, 1'b1);
      pulse_reset();
    end
    repeat (2) @(posedge clk);
  endtask

  initial begin : main
    repeat (3) @(posedge clk);
    #2;
    check_reset("por");
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Reset in the middle of pushing row 2 aborts the fill
    lat = 1;
    launch(1'b0);
    for (int i = 0; i < 500 && pos < 2*COLS + 3; i++) @(posedge clk);
    check("t1_reached_row2", pos >= 2*COLS + 3, 1'b1);
    @(posedge clk); #2;
    rst = 1'b1;
    #2;
    check_reset("midfill_rst");
    @(posedge clk); #2;
    rst = 1'b0;
    repeat (3) @(posedge clk);

    // Ramp data, zero wait, latency 1: refetch starts at BASE, done at cycle 91
    launch(1'b1);
    wait_done("t2");
    check("t2_done_cycle", done_cyc - t0, 91);
    check("t2_writes", pos, 72);

    // Three wait states on word 2
    w2_wait = 3;
    launch(1'b1);
    wait_done("t3");
    check("t3_done_cycle", done_cyc - t0, 94);
    check("t3_w2_read_cycles", w2_rd, 4);
    w2_wait = 0;

    // A FIFO 5 full for 4 cycles at byte 3
    full5_en = 1'b1;
    launch(1'b1);
    wait_done("t4");
    check("t4_done_cycle", done_cyc - t0, 95);
    check("t4_byte3_gap", b3_cyc - b2_cyc, 5);
    full5_en = 1'b0;

    // Stray rdvalid and start pulses
    spur = 1'b1;
    launch(1'b0);
    wait_done("t5");
    check("t5_done_cycle", done_cyc - t0, 91);
    spur = 1'b0;

    // Read latency 5
    lat = 5;
    launch(1'b0);
    wait_done("t6");
    check("t6_done_cycle", done_cyc - t0, 127);

    // Random latency, wait states, full flags and stray events
    for (int r = 0; r < 6; r++) begin
      lat      = int'($urandom_range(1, 4));
      wait_pct = int'($urandom_range(0, 40));
      full_pct = int'($urandom_range(0, 30));
      spur     = bit'($urandom_range(0, 1));
      launch(1'b0);
      wait_done("rand");
      check("rand_writes", pos, TOTAL);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
